mux16_rr_arbiter: RTL and testbench
===================================

Name: mux16_rr_arbiter

Overview:
- Round-robin arbiter that shares one 16:1 bit mux (mux16 datapath) among 16 requesters.
- Produces the registered 4-bit select `sel` for the mux and a one-hot grant back to the requesters.
- Optional hold timeout forces rotation so one requester cannot starve the others.
- Sits between requester logic and the mux16 select input; the mux itself stays outside this block.

Parameters:
- MAX_HOLD, 16: max consecutive cycles one owner may keep the grant while others wait; 0 disables the timeout; legal range 0..255.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  16  request vector; bit n = requester n wants the mux; requester holds it until done
- gnt  output  16  one-hot grant, registered; all-zero when idle
- sel  output  4  registered mux select = index of current/last owner
- busy  output  1  high while any grant is active
- ptr_o  output  4  current round-robin search start (debug/verification)

Behaviour:
- Reset (async assert, sync release): gnt=0, sel=0, busy=0, ptr=0, hold_cnt=0, state=IDLE.
- Reset mid-grant: all outputs clear immediately, without waiting for clk.
- State machine has two states, IDLE and BUSY.
- Pick function: first set bit of req searching ptr, ptr+1, ..., wrapping 15->0.
- IDLE:
  - If req!=0 at a clk edge, grant the picked index n.
  - Same edge: gnt=1<<n, sel=n, busy=1, hold_cnt=0, go BUSY.
  - Latency: req asserted in cycle k -> gnt visible in cycle k+1.
- BUSY, owner o:
  - Release condition: req[o]==0, or (MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 and some req[m]=1 with m!=o).
  - No release: hold_cnt increments; it saturates at 255, and stays at MAX_HOLD-1 when o is the only requester.
  - On release: ptr=(o+1) mod 16, then pick from req with o masked out when req[o]==0.
  - Back-to-back: if a new winner m exists, gnt=1<<m, sel=m, hold_cnt=0, stay BUSY, no idle bubble.
  - Timeout release: o is not masked but sits last in search order, so it is regranted only if it is the sole requester.
  - No winner: gnt=0, busy=0, go IDLE; sel keeps o so the mux output does not glitch.
- Timeout with the owner as the only requester does not release; it keeps the grant.
- Requests arriving in the cycle of release are seen by that same edge's pick.
- ptr wraps 15->0 (4-bit modulo).
- Invariants, checked every cycle:
  - gnt is never multi-hot.
  - gnt!=0 iff busy=1.
  - When busy=1, sel equals the index of the set bit in gnt.
- No combinational path from req to any output; all outputs are registered.

Decomposition:
- Shared package mux16_pkg holds:
  - constants N_REQ=16 and SEL_W=4
  - typedef for the 2-state FSM enum (ST_IDLE, ST_BUSY)
  - typedefs req_vec_t (16 bits) and sel_t (4 bits)
- One combinational sub-module, rr_pick16:
  - Inputs: req, start pointer.
  - Outputs: found flag and 4-bit winner index.
  - Implemented as rotate, priority-encode, un-rotate.
  - Reused in both the IDLE and release paths.

Test Plan:
- Reset, then req=16'h0001 held -> gnt=16'h0001, sel=0, busy=1 one cycle later. Drop req -> next cycle gnt=0, busy=0, sel stays 0, ptr_o=1.
- Reset, req=16'h8421 all held, each owner drops its bit 3 cycles after its grant -> grant order 0, 5, 10, 15 with no idle cycle between owners; after 15 releases, ptr_o=0 (wrap).
- MAX_HOLD=4, req=16'h0003 held constantly -> gnt alternates 0001 (4 cycles) / 0002 (4 cycles) with sel toggling 0/1; no bubbles.
- MAX_HOLD=4, req=16'h0004 alone held 20 cycles -> gnt stays 16'h0004 throughout, never drops or regrants.
- Grant active on requester 7 (sel=7), assert rst between clock edges -> gnt, sel, busy go 0 immediately. Release rst with req=16'h0080 -> regranted 1 cycle after the first clk edge.
- MAX_HOLD=0, req=16'hFFFF held -> requester 0 keeps the grant indefinitely. Drop bit 0 -> requester 1 is granted the next cycle, sel=1.

Source files
------------

// File: rtl/mux16_rr_arbiter_pkg.sv
// mux16_pkg: shared constants, vector types and FSM encoding for the mux16 round-robin arbiter
//   no ports; imported by the interface, the pick sub-module and the top
package mux16_pkg;
   localparam int N_REQ = 16;
   localparam int SEL_W = 4;
   typedef logic [N_REQ-1:0] req_vec_t;
   typedef logic [SEL_W-1:0] sel_t;
   typedef enum logic {ST_IDLE, ST_BUSY} state_t;
   function automatic req_vec_t onehot(sel_t i);
      return req_vec_t'(1) << i;
   endfunction
endpackage

// File: rtl/mux16_rr_arbiter_if.sv
// mux16_rr_arbiter_if: requester/arbiter bundle for the shared 16:1 mux
//   req   requester -> arbiter, one bit per requester
//   gnt   arbiter -> requester, one-hot grant
//   sel   arbiter -> mux, index of current/last owner
//   busy  arbiter -> requester, a grant is active
//   ptr_o arbiter -> observer, round-robin search start
interface mux16_rr_arbiter_if;
   import mux16_pkg::*;
   req_vec_t req;
   req_vec_t gnt;
   sel_t     sel;
   logic     busy;
   sel_t     ptr_o;
   modport master (output req, input gnt, sel, busy, ptr_o);
   modport slave  (input req, output gnt, sel, busy, ptr_o);
endinterface

// File: rtl/mux16_rr_arbiter_rr_pick16.sv
// rr_pick16: combinational round-robin pick of the first set request at or after start
//   req   request vector
//   start search start index, search wraps 15 -> 0
//   found any request set
//   win   winning index
module rr_pick16
   import mux16_pkg::*;
(
   input  req_vec_t req,
   input  sel_t     start,
   output logic     found,
   output sel_t     win
);
   req_vec_t rot;
   sel_t     off;
   always_comb begin
      // rotate so start lands on bit 0, take the lowest set bit, then rotate back
      rot = req_vec_t'({req, req} >> start);
      off = '0;
      for (int i = N_REQ - 1; i >= 0; i--) off = rot[i] ? sel_t'(i) : off;
      found = |req;
      win = off + start;
   end
endmodule

// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: round-robin arbiter driving the select of a shared 16:1 bit mux
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   slave side of mux16_rr_arbiter_if (req in; gnt, sel, busy, ptr_o out, all registered)
//   MAX_HOLD  cycles an owner may keep the grant while others wait, 0 = no timeout
module mux16_rr_arbiter
   import mux16_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16
)(
   input logic               clk,
   input logic               rst,
   mux16_rr_arbiter_if.slave bus
);
   localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);
   state_t     state;
   req_vec_t   gnt;
   sel_t       sel;
   sel_t       ptr;
   logic       busy;
   logic [7:0] hold_cnt;
   logic       others;
   logic       at_limit;
   logic       release_now;
   logic       found;
   sel_t       win;
   sel_t       start;
   always_comb begin
      others = |(bus.req & ~onehot(sel));
      at_limit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
      release_now = !bus.req[sel] || (at_limit && others);
      // on release the search begins just past the owner, so a timed-out owner comes last;
      // a dropped owner has req[sel]==0 already, which is the masking it needs
      start = (state == ST_BUSY) ? sel + 1'b1 : ptr;
   end
   rr_pick16 u_pick (
      .req   (bus.req),
      .start (start),
      .found (found),
      .win   (win)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         gnt <= '0;
         sel <= '0;
         ptr <= '0;
         busy <= 1'b0;
         hold_cnt <= '0;
      end else if (state == ST_IDLE) begin
         if (found) begin
            state <= ST_BUSY;
            gnt <= onehot(win);
            sel <= win;
            busy <= 1'b1;
            hold_cnt <= '0;
         end
      end else if (!release_now) begin
         // a sole requester at the limit parks there so it can be released once someone else asks
         hold_cnt <= (hold_cnt == 8'hFF || at_limit) ? hold_cnt : hold_cnt + 8'd1;
      end else begin
         ptr <= sel + 1'b1;
         if (found) begin
            gnt <= onehot(win);
            sel <= win;
            hold_cnt <= '0;
         end else begin
            // sel keeps the last owner so the mux output stays put while idle
            state <= ST_IDLE;
            gnt <= '0;
            busy <= 1'b0;
         end
      end
   end
   assign bus.gnt = gnt;
   assign bus.sel = sel;
   assign bus.busy = busy;
   assign bus.ptr_o = ptr;
endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// tb_mux16_rr_arbiter: checks three arbiters (MAX_HOLD 16, 4, 0) against a behavioural model
module tb_mux16_rr_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mux16_rr_arbiter_if if16 ();
   mux16_rr_arbiter_if if4 ();
   mux16_rr_arbiter_if if0 ();

   mux16_rr_arbiter #(.MAX_HOLD(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));
   mux16_rr_arbiter #(.MAX_HOLD(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));
   mux16_rr_arbiter #(.MAX_HOLD(0))  dut0  (.clk(clk), .rst(rst), .bus(if0));

   logic [15:0] rq [3];
   assign if16.req = rq[0];
   assign if4.req  = rq[1];
   assign if0.req  = rq[2];

   logic [15:0] o_gnt [3];
   logic [3:0]  o_sel [3];
   logic [3:0]  o_ptr [3];
   logic        o_busy [3];
   assign o_gnt[0] = if16.gnt;  assign o_sel[0] = if16.sel;  assign o_ptr[0] = if16.ptr_o;  assign o_busy[0] = if16.busy;
   assign o_gnt[1] = if4.gnt;   assign o_sel[1] = if4.sel;   assign o_ptr[1] = if4.ptr_o;   assign o_busy[1] = if4.busy;
   assign o_gnt[2] = if0.gnt;   assign o_sel[2] = if0.sel;   assign o_ptr[2] = if0.ptr_o;   assign o_busy[2] = if0.busy;

   int mh [3] = '{16, 4, 0};
   bit m_busy [3];
   int m_own [3];
   int m_sel [3];
   int m_ptr [3];
   int m_hc [3];

   int checks = 0;
   int errors = 0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(logic [15:0] r, int p);
      for (int k = 0; k < 16; k++) if (r[(p + k) % 16]) return (p + k) % 16;
      return -1;
   endfunction

   function automatic int idx(logic [15:0] v);
      for (int k = 0; k < 16; k++) if (v[k]) return k;
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_busy[i] = 0; m_own[i] = 0; m_sel[i] = 0; m_ptr[i] = 0; m_hc[i] = 0;
      end
   endtask

   task automatic model_step(int i);
      logic [15:0] r;
      int o, w;
      bit others, rel, parked;
      r = rq[i];
      if (!m_busy[i]) begin
         if (r != 0) begin
            w = pick(r, m_ptr[i]);
            m_own[i] = w; m_sel[i] = w; m_busy[i] = 1; m_hc[i] = 0;
         end
      end else begin
         o = m_own[i];
         others = (r & ~(16'h1 << o)) != 0;
         parked = mh[i] != 0 && m_hc[i] == mh[i] - 1;
         rel = !r[o] || (parked && others);
         if (!rel) begin
            if (m_hc[i] < 255 && !parked) m_hc[i]++;
         end else begin
            m_ptr[i] = (o + 1) % 16;
            w = pick(r, m_ptr[i]);
            if (w >= 0) begin
               m_own[i] = w; m_sel[i] = w; m_hc[i] = 0;
            end else m_busy[i] = 0;
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("gnt%0d", i), o_gnt[i], m_busy[i] ? (16'h1 << m_own[i]) : 16'h0);
         chk($sformatf("sel%0d", i), o_sel[i], m_sel[i]);
         chk($sformatf("busy%0d", i), o_busy[i], m_busy[i]);
         chk($sformatf("ptr%0d", i), o_ptr[i], m_ptr[i]);
         chk($sformatf("inv_onehot%0d", i), $countones(o_gnt[i]) <= 1, 1);
         chk($sformatf("inv_busy%0d", i), o_gnt[i] != 0, o_busy[i]);
         if (o_busy[i]) chk($sformatf("inv_sel%0d", i), o_gnt[i][o_sel[i]], 1'b1);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else for (int i = 0; i < 3; i++) model_step(i);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      tick();
      tick();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int order[$];
      int eo [4] = '{0, 5, 10, 15};
      int last, cnt, bub, w;
      rq[0] = 0; rq[1] = 0; rq[2] = 0;
      model_reset();
      do_reset();
      check_all();
      chk("reset_gnt", o_gnt[0], 16'h0);

      // single requester grant and release
      rq[0] = 16'h0001;
      tick();
      chk("t1_gnt", o_gnt[0], 16'h0001);
      chk("t1_busy", o_busy[0], 1'b1);
      rq[0] = 16'h0000;
      tick();
      chk("t1_idle_gnt", o_gnt[0], 16'h0000);
      chk("t1_idle_sel", o_sel[0], 4'd0);
      chk("t1_idle_ptr", o_ptr[0], 4'd1);

      // four requesters, each dropping three cycles after its grant
      do_reset();
      rq[0] = 16'h8421;
      last = -1; cnt = 0; bub = 0;
      for (int t = 0; t < 40 && rq[0] != 0; t++) begin
         tick();
         if (o_busy[0]) begin
            w = idx(o_gnt[0]);
            if (w != last) begin order.push_back(w); last = w; cnt = 1; end
            else cnt++;
            if (cnt == 3 && w >= 0) rq[0] = rq[0] & ~(16'h1 << w);
         end else if (order.size() > 0) bub++;
      end
      tick();
      chk("t2_count", order.size(), 4);
      for (int k = 0; k < 4; k++) chk($sformatf("t2_order%0d", k), k < order.size() ? order[k] : -1, eo[k]);
      chk("t2_bubbles", bub, 0);
      chk("t2_ptr_wrap", o_ptr[0], 4'd0);
      chk("t2_idle", o_busy[0], 1'b0);

      // timeout alternation with two requesters
      do_reset();
      rq[1] = 16'h0003;
      for (int j = 0; j < 24; j++) begin
         tick();
         chk($sformatf("t3_gnt%0d", j), o_gnt[1], ((j / 4) % 2) ? 16'h0002 : 16'h0001);
         chk($sformatf("t3_sel%0d", j), o_sel[1], (j / 4) % 2);
      end

      // timeout with a sole requester keeps the grant
      rq[1] = 16'h0000;
      tick();
      rq[1] = 16'h0004;
      for (int j = 0; j < 20; j++) begin
         tick();
         chk($sformatf("t4_gnt%0d", j), o_gnt[1], 16'h0004);
      end
      rq[1] = 16'h0000;

      // asynchronous reset in the middle of a grant
      do_reset();
      rq[0] = 16'h0080;
      tick();
      tick();
      chk("t5_pre_sel", o_sel[0], 4'd7);
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      chk("t5_async_gnt", o_gnt[0], 16'h0);
      chk("t5_async_sel", o_sel[0], 4'd0);
      chk("t5_async_busy", o_busy[0], 1'b0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("t5_regrant", o_gnt[0], 16'h0080);
      rq[0] = 16'h0000;

      // no timeout: requester 0 keeps the grant past hold counter saturation
      do_reset();
      rq[2] = 16'hFFFF;
      for (int j = 0; j < 300; j++) tick();
      chk("t6_hold", o_gnt[2], 16'h0001);
      rq[2] = 16'hFFFE;
      tick();
      chk("t6_next_gnt", o_gnt[2], 16'h0002);
      chk("t6_next_sel", o_sel[2], 4'd1);

      // randomized traffic on all three arbiters
      do_reset();
      for (int t = 0; t < 3000; t++) begin
         for (int i = 0; i < 3; i++)
            if ($urandom_range(3) == 0) rq[i] = 16'($urandom & $urandom & $urandom);
         if (t == 1500) begin
            rst = 1'b1;
            model_reset();
            #1;
            check_all();
            @(negedge clk);
            rst = 1'b0;
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
